sha_core_input_feeder: RTL
==========================

SHA_CORE_INPUT_FEEDER -- requirements
Module: sha_core_input_feeder

Interface
REQ-001 Parameter: MIN_JOB_SPACING, default 16, minimum cycles from one newblock beat to the next newblock beat.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: job_valid  input  1  job offer.
REQ-005 Port: job_ready  output  1  feeder accepts a job this cycle.
REQ-006 Port: job_state  input  HashState  midstate for the job.
REQ-007 Port: job_w1, job_w2, job_w3  input  32 each  header tail words.
REQ-008 Port: job_beats  input  32  valid beats to issue, including the newblock beat; 0 means 2^32.
REQ-009 Port: stall  input  1  suppresses beat issue this cycle.
REQ-010 Port: abort  input  1  terminates the running job.
REQ-011 Port: out  coreInputsIfc.writer  -  drives valid, newblock, hashstate, w1, w2, w3 to the core.
REQ-012 Port: busy  output  1  state is not IDLE.
REQ-013 Port: done  output  1  one-cycle pulse on normal job completion.
REQ-014 Port: beats_issued  output  32  valid beats issued for the current or last job.

Function
REQ-015 FSM states: IDLE, RUN, GAP.
REQ-016 job_ready = (state==IDLE); accept = job_valid & job_ready.
REQ-017 On accept:
  - latch job_state into out.hashstate and job_w1..w3 into out.w1..w3;
  - load remaining = job_beats (0 loads 2^32, 33-bit counter);
  - clear beats_issued;
  - go to RUN.
REQ-018 In RUN: out.valid = ~stall & ~abort; combinational, no added latency.
REQ-019 First valid beat of a job: out.newblock=1. All other cycles: out.newblock=0. out.newblock is never 1 while out.valid=0.
REQ-020 Earliest newblock beat: the cycle after accept. A stall in that cycle defers it; it is not dropped.
REQ-021 Each valid beat:
  - remaining decrements by 1;
  - beats_issued increments by 1, wrapping modulo 2^32.
REQ-022 Valid beat with remaining==1:
  - done=1 in the next cycle;
  - next state GAP if fewer than MIN_JOB_SPACING-1 cycles have elapsed since the newblock beat, else IDLE.
REQ-023 Spacing counter: loads MIN_JOB_SPACING-1 on the newblock beat, decrements to 0 and saturates. GAP exits to IDLE when it reaches 0.
REQ-024 Consequence: two newblock beats are never closer than MIN_JOB_SPACING cycles.
REQ-025 out.hashstate and out.w1..w3 change only on accept. They hold between jobs and during stall, GAP and IDLE, so downstream delayed samplers see stable words.
REQ-026 abort in RUN:
  - no beat that cycle;
  - next state GAP, or IDLE if spacing is already 0;
  - done is not asserted;
  - beats_issued retains its value.
REQ-027 abort outside RUN is ignored.
REQ-028 abort has priority over stall and over last-beat completion in the same cycle.
REQ-029 busy = (state!=IDLE).
REQ-030 done is never asserted for more than one cycle per job.

Reset
REQ-031 While rst=1, next state is:
  - state IDLE, out.valid=0, out.newblock=0, done=0;
  - out.hashstate=0, out.w1..w3=0, beats_issued=0;
  - spacing=0, remaining=0.
REQ-032 job_ready=1 in the first cycle after rst deasserts.
REQ-033 rst mid-job: the job is dropped, no done pulse, no further beats.

Verification
REQ-034 Single job: job_beats=4, w1=0xA5A5A5A5, no stall.
  - Accept at t; valid at t+1..t+4; newblock only at t+1.
  - done at t+5; state GAP until spacing expires; job_ready returns at t+16.
REQ-035 Stall: job_beats=3, stall high at t+1 and t+3.
  - newblock beat at t+2; beats at t+2, t+4, t+5.
  - out.w1..w3 constant throughout; done at t+6; beats_issued=3.
REQ-036 Spacing: job_beats=1 back-to-back offers.
  - Newblock beats exactly MIN_JOB_SPACING=16 cycles apart.
  - Second job's w words appear only after first job's GAP.
REQ-037 Abort: job_beats=100, abort at 5th RUN cycle.
  - 4 beats issued, no done, beats_issued=4.
  - Next newblock beat is no earlier than 16 cycles after the first.
REQ-038 Boundary:
  - job_beats=0 runs 2^32 beats, beats_issued wraps to 0, done fires once (or use a forced counter preload in simulation).
  - abort coinciding with the last beat gives no beat and no done.
REQ-039 Reset mid-RUN: rst at beat 2 → valid=0 next cycle, outputs zeroed, job_ready=1 after release.

Source files
------------

// File: rtl/sha_core_input_feeder_if.sv
// Shared types and the feeder-to-core bundle carrying one hash beat.

package sha_core_pkg;
  typedef logic [255:0] HashState;
endpackage

interface coreInputsIfc;
  logic                  valid;
  logic                  newblock;
  sha_core_pkg::HashState hashstate;
  logic [31:0]           w1;
  logic [31:0]           w2;
  logic [31:0]           w3;

  modport writer (output valid, newblock, hashstate, w1, w2, w3);
  modport reader (input  valid, newblock, hashstate, w1, w2, w3);
endinterface

// File: rtl/sha_core_input_feeder.sv
// Accepts one hashing job at a time and issues its beats to the SHA core,
// holding the job words stable and keeping newblock beats spaced apart.

module sha_core_input_feeder
  import sha_core_pkg::*;
#(
  parameter int MIN_JOB_SPACING = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  HashState     job_state,
  input  logic [31:0]  job_w1,
  input  logic [31:0]  job_w2,
  input  logic [31:0]  job_w3,
  input  logic [31:0]  job_beats,
  input  logic         stall,
  input  logic         abort,
  coreInputsIfc.writer out,
  output logic         busy,
  output logic         done,
  output logic [31:0]  beats_issued
);

  localparam int SW = (MIN_JOB_SPACING > 2) ? $clog2(MIN_JOB_SPACING) : 1;
  localparam logic [SW-1:0] SPACING_LOAD = SW'(MIN_JOB_SPACING - 1);
  localparam logic [32:0] FULL_JOB = 33'h1_0000_0000;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t        state;
  state_t        state_next;
  logic [32:0]   remaining;
  logic [SW-1:0] spacing;
  logic [SW-1:0] spacing_now;
  logic [SW-1:0] spacing_after;
  logic          first_pending;
  logic          accept;
  logic          beat;
  logic          newblock_beat;
  logic          last_beat;
  logic          done_pulse;
  logic [31:0]   issued;
  HashState      hold_state;
  logic [31:0]   hold_w1;
  logic [31:0]   hold_w2;
  logic [31:0]   hold_w3;

  assign job_ready     = (state == IDLE);
  assign accept        = job_valid & job_ready;
  assign busy          = (state != IDLE);
  assign beat          = (state == RUN) & ~stall & ~abort;
  assign newblock_beat = beat & first_pending;
  assign last_beat     = beat & (remaining == 33'd1);

  // The newblock beat itself counts as the first spacing cycle, so the
  // reload value is visible in that cycle and starts counting down from it.
  assign spacing_now   = newblock_beat ? SPACING_LOAD : spacing;
  assign spacing_after = (spacing_now == '0) ? '0 : spacing_now - SW'(1);

  assign out.valid     = beat;
  assign out.newblock  = newblock_beat;
  assign out.hashstate = hold_state;
  assign out.w1        = hold_w1;
  assign out.w2        = hold_w2;
  assign out.w3        = hold_w3;
  assign done          = done_pulse;
  assign beats_issued  = issued;

  // Next-state selection; abort wins over both stall and the final beat.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = (spacing_now == '0) ? IDLE : GAP;
        end else if (last_beat) begin
          state_next = (spacing_now != '0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (spacing_after == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Job registers, beat accounting and the spacing countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      remaining     <= '0;
      spacing       <= '0;
      first_pending <= 1'b0;
      done_pulse    <= 1'b0;
      issued        <= '0;
      hold_state    <= '0;
      hold_w1       <= '0;
      hold_w2       <= '0;
      hold_w3       <= '0;
    end else begin
      state      <= state_next;
      spacing    <= spacing_after;
      done_pulse <= last_beat;
      if (accept) begin
        hold_state    <= job_state;
        hold_w1       <= job_w1;
        hold_w2       <= job_w2;
        hold_w3       <= job_w3;
        remaining     <= (job_beats == 32'd0) ? FULL_JOB : {1'b0, job_beats};
        issued        <= '0;
        first_pending <= 1'b1;
      end else if (beat) begin
        remaining     <= remaining - 33'd1;
        issued        <= issued + 32'd1;
        first_pending <= 1'b0;
      end
    end
  end

endmodule
